// File: rtl/alu_writeback_collector.sv
// Pairs issue tags with ALU results after a fixed latency, buffers them and hands them to writeback.
// Optional counters stat_retired/stat_stall are built when ALU_WB_STATS_EN is defined.
module alu_writeback_collector #(
  parameter int ALU_LATENCY = 3,
  parameter int FIFO_DEPTH  = 4,
  parameter int RD_W        = 11
)(
  input  logic            clock,
  input  logic            reset,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [3:0]      issue_funct,
  input  logic [RD_W-1:0] issue_rd,
  input  logic [15:0]     alu_out,
  input  logic [31:0]     alu_mul_out,
  input  logic            alu_carry_out,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [RD_W-1:0] wb_rd,
  output logic [15:0]     wb_data,
  output logic            wb_carry_vld,
  output logic            wb_carry
`ifdef ALU_WB_STATS_EN
  ,
  output logic [31:0]     stat_retired,
  output logic [31:0]     stat_stall
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [3:0] F_MULH = 4'd3, F_MULS = 4'd4, F_SEQ = 4'd11,
                         F_SLTU = 4'd12, F_SLTS = 4'd13, F_ADDC = 4'd15;

  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic [15:0]     data;
    logic            cv;
    logic            c;
  } wb_ent_t;

  logic [ALU_LATENCY-1:0]           r_tag_vld;
  logic [ALU_LATENCY-1:0][3:0]      r_tag_funct;
  logic [ALU_LATENCY-1:0][RD_W-1:0] r_tag_rd;
  wb_ent_t                          r_mem [FIFO_DEPTH];
  logic [PW:0]                      r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]                    r_credits;

  logic       w_fire, w_pop, w_push, w_full, w_empty, w_wb_valid;
  logic [3:0] w_last_funct;
  wb_ent_t    w_ent, w_head;
  logic       w_unused_ok;

  // Credits cover tags in flight plus buffered entries, so a push always finds room.
  assign issue_ready = reset && (r_credits < CW'(FIFO_DEPTH));
  assign w_fire      = issue_valid && issue_ready;
  assign w_push      = r_tag_vld[ALU_LATENCY-1];
  assign w_last_funct = r_tag_funct[ALU_LATENCY-1];

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_tag_vld <= '0;
    end else begin
      r_tag_vld[0] <= w_fire;
      for (int i = 1; i < ALU_LATENCY; i++) r_tag_vld[i] <= r_tag_vld[i-1];
    end
  end

  always_ff @(posedge clock) begin
    r_tag_funct[0] <= issue_funct;
    r_tag_rd[0]    <= issue_rd;
    for (int i = 1; i < ALU_LATENCY; i++) begin
      r_tag_funct[i] <= r_tag_funct[i-1];
      r_tag_rd[i]    <= r_tag_rd[i-1];
    end
  end

  always_comb begin
    w_ent    = '0;
    w_ent.rd = r_tag_rd[ALU_LATENCY-1];
    case (w_last_funct)
      F_MULH, F_MULS:         w_ent.data = alu_mul_out[31:16];
      F_SEQ, F_SLTU, F_SLTS:  w_ent.data = {15'b0, alu_out[0]};
      default:                w_ent.data = alu_out;
    endcase
    if (w_last_funct == F_ADDC) begin
      w_ent.cv = 1'b1;
      w_ent.c  = alu_carry_out;
    end
  end

  assign w_unused_ok = ^alu_mul_out[15:0];

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                      (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_wb_valid = reset && !w_empty;
  assign w_pop      = w_wb_valid && wb_ready;

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr[PW-1:0]] <= w_ent;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_credits <= '0;
    end else begin
      r_wr_ptr  <= r_wr_ptr + {{PW{1'b0}}, w_push};
      r_rd_ptr  <= r_rd_ptr + {{PW{1'b0}}, w_pop};
      r_credits <= r_credits + CW'(w_fire) - CW'(w_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset && w_push) assert (!w_full);
  end

  // Head is read straight from storage; fields are zeroed whenever nothing is offered.
  assign w_head       = r_mem[r_rd_ptr[PW-1:0]];
  assign wb_valid     = w_wb_valid;
  assign wb_rd        = w_wb_valid ? w_head.rd   : '0;
  assign wb_data      = w_wb_valid ? w_head.data : '0;
  assign wb_carry_vld = w_wb_valid && w_head.cv;
  assign wb_carry     = w_wb_valid && w_head.c;

`ifdef ALU_WB_STATS_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      stat_retired <= '0;
      stat_stall   <= '0;
    end else begin
      stat_retired <= stat_retired + {31'b0, w_pop};
      stat_stall   <= stat_stall + {31'b0, issue_valid && !issue_ready};
    end
  end
`endif
endmodule

// File: tb/tb_alu_writeback_collector.sv
// Randomized and directed bench for alu_writeback_collector with a queue-based result model.
module tb_alu_writeback_collector;
  localparam int LAT = 3;
  localparam int DEPTH = 4;
  localparam int RD_W = 11;

  logic            clock, reset;
  logic            issue_valid, issue_ready;
  logic [3:0]      issue_funct;
  logic [RD_W-1:0] issue_rd;
  logic [15:0]     alu_out;
  logic [31:0]     alu_mul_out;
  logic            alu_carry_out;
  logic            wb_valid, wb_ready;
  logic [RD_W-1:0] wb_rd;
  logic [15:0]     wb_data;
  logic            wb_carry_vld, wb_carry;
`ifdef ALU_WB_STATS_EN
  logic [31:0]     stat_retired, stat_stall;
`endif

  alu_writeback_collector #(.ALU_LATENCY(LAT), .FIFO_DEPTH(DEPTH), .RD_W(RD_W)) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_funct(issue_funct), .issue_rd(issue_rd),
    .alu_out(alu_out), .alu_mul_out(alu_mul_out), .alu_carry_out(alu_carry_out),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_carry_vld(wb_carry_vld), .wb_carry(wb_carry)
`ifdef ALU_WB_STATS_EN
    , .stat_retired(stat_retired), .stat_stall(stat_stall)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ALU stand-in: results of a fired op emerge LAT cycles later, garbage otherwise.
  logic [15:0] op_out;
  logic [31:0] op_mul;
  logic        op_c;
  logic [15:0] ln_o [LAT];
  logic [31:0] ln_m [LAT];
  logic        ln_c [LAT];
  always @(posedge clock) begin
    ln_o[0] <= (issue_valid && issue_ready) ? op_out : 16'($urandom);
    ln_m[0] <= (issue_valid && issue_ready) ? op_mul : $urandom;
    ln_c[0] <= (issue_valid && issue_ready) ? op_c   : 1'($urandom);
    for (int i = 1; i < LAT; i++) begin
      ln_o[i] <= ln_o[i-1];
      ln_m[i] <= ln_m[i-1];
      ln_c[i] <= ln_c[i-1];
    end
  end
  assign alu_out       = ln_o[LAT-1];
  assign alu_mul_out   = ln_m[LAT-1];
  assign alu_carry_out = ln_c[LAT-1];

  typedef struct {
    logic [RD_W-1:0] rd;
    logic [15:0]     d;
    logic            cv;
    logic            c;
    int              avail;
  } exp_t;
  exp_t q[$];
  logic [RD_W-1:0] popped[$];

  int ntests = 0, nfail = 0, cyc = 0;
  logic cur_rst;
  logic s_valid, s_ready, s_cv, s_c, s_fire;
  logic [RD_W-1:0] s_rd;
  logic [15:0] s_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] f, input logic [RD_W-1:0] rd,
                              input logic [15:0] ao, input logic [31:0] mo, input logic co,
                              input int avail);
    exp_t e;
    e.rd = rd; e.avail = avail;
    if (f == 4'd3 || f == 4'd4)                     e.d = mo[31:16];
    else if (f == 4'd11 || f == 4'd12 || f == 4'd13) e.d = {15'b0, ao[0]};
    else                                             e.d = ao;
    e.cv = (f == 4'd15);
    e.c  = (f == 4'd15) ? co : 1'b0;
    return e;
  endfunction

  // One cycle: check outputs at negedge, drive new inputs, advance the model.
  task automatic step(input logic iv, input logic [3:0] f, input logic [RD_W-1:0] rd,
                      input logic [15:0] ao, input logic [31:0] mo, input logic co,
                      input logic wr, input logic rn);
    logic avail_now, fire_m, pop_m;
    @(negedge clock);
    cyc++;
    avail_now = (q.size() > 0) && (cyc >= q[0].avail);
    chk("issue_ready", issue_ready, cur_rst && (q.size() < DEPTH));
    chk("wb_valid", wb_valid, cur_rst && avail_now);
    if (cur_rst && avail_now) begin
      chk("wb_rd", wb_rd, q[0].rd);
      chk("wb_data", wb_data, q[0].d);
      chk("wb_carry_vld", wb_carry_vld, q[0].cv);
      chk("wb_carry", wb_carry, q[0].c);
    end
    if (!cur_rst) begin
      chk("rst_wb_rd", wb_rd, 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_wb_carry_vld", wb_carry_vld, 0);
      chk("rst_wb_carry", wb_carry, 0);
    end
    s_valid = wb_valid; s_ready = issue_ready; s_rd = wb_rd;
    s_data = wb_data; s_cv = wb_carry_vld; s_c = wb_carry;
    reset = rn; issue_valid = iv; issue_funct = f; issue_rd = rd;
    op_out = ao; op_mul = mo; op_c = co; wb_ready = wr;
    cur_rst = rn;
    fire_m = iv && rn && (q.size() < DEPTH);
    pop_m  = avail_now && wr && rn;
    s_fire = fire_m;
    if (pop_m) begin
      popped.push_back(q[0].rd);
      void'(q.pop_front());
    end
    if (fire_m) q.push_back(mk(f, rd, ao, mo, co, cyc + LAT + 1));
    if (!rn) q.delete();
  endtask

  task automatic idle(input logic wr);
    step(1'b0, 4'($urandom), RD_W'($urandom), 16'($urandom), $urandom, 1'($urandom), wr, 1'b1);
  endtask

  int nfire;

  initial begin
    reset = 1'b0; cur_rst = 1'b0; issue_valid = 1'b0; issue_funct = '0; issue_rd = '0;
    op_out = '0; op_mul = '0; op_c = 1'b0; wb_ready = 1'b0;

    repeat (3) step(1'b0, 4'd0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("reset_ready", s_ready, 0);
    chk("reset_valid", s_valid, 0);
    idle(1'b0); idle(1'b0);
    chk("ready_after_reset", s_ready, 1);

    // Single ADD: result appears exactly ALU_LATENCY+1 cycles after fire
    step(1'b1, 4'd0, 11'd5, 16'h1234, 32'h0, 1'b0, 1'b0, 1'b1);
    repeat (3) idle(1'b0);
    chk("add_not_early", s_valid, 0);
    idle(1'b0);
    chk("add_valid", s_valid, 1);
    chk("add_rd", s_rd, 5);
    chk("add_data", s_data, 16'h1234);
    chk("add_cv", s_cv, 0);
    idle(1'b1); idle(1'b0);

    step(1'b1, 4'd3, 11'd9, 16'h5555, 32'hABCD0001, 1'b0, 1'b0, 1'b1);
    repeat (4) idle(1'b0);
    chk("mulh_data", s_data, 16'hABCD);
    idle(1'b1); idle(1'b0);

    step(1'b1, 4'd15, 11'd2, 16'h0000, 32'h12345678, 1'b1, 1'b0, 1'b1);
    repeat (4) idle(1'b0);
    chk("addc_data", s_data, 16'h0000);
    chk("addc_cv", s_cv, 1);
    chk("addc_carry", s_c, 1);
    idle(1'b1); idle(1'b0);

    // Fill with wb_ready low: only FIFO_DEPTH issues may fire
    nfire = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 4'd0, RD_W'(nfire), 16'($urandom), $urandom, 1'b0, 1'b0, 1'b1);
      if (s_fire) nfire++;
    end
    idle(1'b0);
    chk("fill_fires", nfire, 4);
    chk("fill_ready_low", s_ready, 0);
    popped.delete();
    repeat (8) idle(1'b1);
    chk("drain_count", popped.size(), 4);
    for (int i = 0; i < 4 && i < popped.size(); i++) chk("drain_order", popped[i], i);

    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 3) != 0, 4'($urandom), RD_W'($urandom), 16'($urandom),
           $urandom, 1'($urandom), 1'($urandom), 1'b1);
    repeat (12) idle(1'b1);
    chk("random_drained", s_valid, 0);

    // Reset with two ops in the tag pipe and two in the FIFO
    step(1'b1, 4'd0, 11'd1, 16'h0101, '0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'd0, 11'd2, 16'h0202, '0, 1'b0, 1'b0, 1'b1);
    idle(1'b0); idle(1'b0);
    step(1'b1, 4'd0, 11'd3, 16'h0303, '0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 4'd0, 11'd4, 16'h0404, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 4'd0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    chk("midrst_valid", s_valid, 0);
    idle(1'b0);
    chk("midrst_credits_free", s_ready, 1);
    chk("midrst_empty", s_valid, 0);
    step(1'b1, 4'd0, 11'd7, 16'h0777, '0, 1'b0, 1'b0, 1'b1);
    repeat (4) idle(1'b0);
    chk("post_rst_valid", s_valid, 1);
    chk("post_rst_rd", s_rd, 7);
    chk("post_rst_data", s_data, 16'h0777);
    idle(1'b1);
    repeat (6) idle(1'b1);
    chk("post_rst_no_stale", s_valid, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
